// File: rtl/axis_tg_pkg.sv
// Shared types and constants for the AXI-Stream traffic generator/checker.
// The head-word helper fixes the layout of the first flit of every packet.
`timescale 1ns/1ps
package axis_tg_pkg;

  typedef enum logic [2:0] {
    TG_IDLE,
    TG_HEAD,
    TG_BODY,
    TG_GAP,
    TG_DONE
  } tg_state_e;

  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_RR    = 2'd1;
  localparam logic [1:0] MODE_RAND  = 2'd2;

  localparam int HEAD_SEQ_LSB = 0;
  localparam int HEAD_SEQ_W   = 16;
  localparam int HEAD_SRC_LSB = 24;
  localparam int HEAD_SRC_W   = 8;

  function automatic logic [31:0] head_word(input logic [7:0] src, input logic [15:0] seq);
    head_word = '0;
    head_word[HEAD_SRC_LSB +: HEAD_SRC_W] = src;
    head_word[HEAD_SEQ_LSB +: HEAD_SEQ_W] = seq;
  endfunction

endpackage

// File: rtl/tg_lfsr.sv
// Fibonacci-style LFSR: shifts left, feedback is the parity of the tapped bits.
`timescale 1ns/1ps
module tg_lfsr #(
  parameter int            DW   = 32,
  parameter logic [DW-1:0] SEED = 32'hACE1_2468,
  parameter logic [DW-1:0] TAPS = 32'h8020_0003
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [DW-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[DW-2:0], ^(q & TAPS)};
    end
  end

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream traffic generator (master side) and framing checker (slave side)
// for one mesh endpoint.
`timescale 1ns/1ps
module axis_traffic_gen
  import axis_tg_pkg::*;
#(
  parameter int                 TDATAW       = 32,
  parameter int                 TDESTW       = 4,
  parameter int                 NUM_DESTS    = 4,
  parameter int                 SRC_ID       = 0,
  parameter bit                 SKIP_SELF    = 1'b1,
  parameter int                 MAX_PKT_LEN  = 16,
  parameter int                 LFSR_DW      = 32,
  parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = 32'hACE1_2468,
  parameter logic [LFSR_DW-1:0] LFSR_TAPS    = 32'h8020_0003,
  localparam int                LENW         = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [TDESTW-1:0] fixed_dest,
  input  logic [15:0]       num_pkts,
  input  logic [LENW-1:0]   pkt_len,
  input  logic [7:0]        gap,
  output logic              axis_m_tvalid,
  input  logic              axis_m_tready,
  output logic [TDATAW-1:0] axis_m_tdata,
  output logic              axis_m_tlast,
  output logic [TDESTW-1:0] axis_m_tdest,
  input  logic              axis_s_tvalid,
  output logic              axis_s_tready,
  input  logic [TDATAW-1:0] axis_s_tdata,
  input  logic              axis_s_tlast,
  input  logic [TDESTW-1:0] axis_s_tdest,
  output logic              busy,
  output logic              done,
  output logic [15:0]       tx_pkt_cnt,
  output logic [15:0]       rx_pkt_cnt,
  output logic [31:0]       rx_flit_cnt,
  output logic [15:0]       rx_err_cnt
);

  tg_state_e           state_q, state_d;
  logic [15:0]         num_pkts_q;
  logic [LENW-1:0]     pkt_len_q, flit_idx_q;
  logic [7:0]          gap_q, gap_cnt_q;
  logic [15:0]         tx_pkt_cnt_q;
  logic [TDESTW-1:0]   dest_q, rr_ptr_q, rr_next, next_dest;
  logic [LFSR_DW-1:0]  lfsr_q, lfsr_now;
  logic                tx_valid, tx_accept, tx_last, lfsr_en;
  logic                start_run, enter_head, run_done;
  logic [15:0]         rx_len_q;
  logic                rx_unused;

  function automatic logic [TDESTW-1:0] fold_dest(input int v);
    int d;
    d = v % NUM_DESTS;
    if (SKIP_SELF && d == SRC_ID) d = (d + 1) % NUM_DESTS;
    return TDESTW'(d);
  endfunction

  tg_lfsr #(.DW(LFSR_DW), .SEED(LFSR_DEFAULT), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (lfsr_en),
    .q   (lfsr_q)
  );

  assign tx_valid  = (state_q == TG_HEAD) || (state_q == TG_BODY);
  assign tx_accept = tx_valid && axis_m_tready;
  assign tx_last   = tx_valid && (flit_idx_q == pkt_len_q - LENW'(1));
  assign lfsr_en   = tx_accept && (state_q == TG_BODY);
  assign start_run = start && ((state_q == TG_IDLE) || (state_q == TG_DONE));
  assign run_done  = (17'(tx_pkt_cnt_q) + 17'd1) == 17'(num_pkts_q);

  // A head entered on the last body accept must see the LFSR value after that flit's step.
  assign lfsr_now = lfsr_en ? {lfsr_q[LFSR_DW-2:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;

  always_comb begin
    rr_next = fold_dest(int'(rr_ptr_q) + 1);
    case (mode)
      MODE_RR:   next_dest = rr_next;
      MODE_RAND: next_dest = fold_dest(int'(lfsr_now[TDESTW-1:0]));
      default:   next_dest = fixed_dest;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    enter_head = 1'b0;
    case (state_q)
      TG_IDLE, TG_DONE: begin
        if (start) begin
          if (num_pkts == '0) begin
            state_d = TG_DONE;
          end else begin
            state_d    = TG_HEAD;
            enter_head = 1'b1;
          end
        end
      end
      TG_HEAD, TG_BODY: begin
        if (tx_accept) begin
          if (!tx_last) begin
            state_d = TG_BODY;
          end else if (run_done) begin
            state_d = TG_DONE;
          end else if (gap_q == '0) begin
            state_d    = TG_HEAD;
            enter_head = 1'b1;
          end else begin
            state_d = TG_GAP;
          end
        end
      end
      TG_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d    = TG_HEAD;
          enter_head = 1'b1;
        end
      end
      default: state_d = TG_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= TG_IDLE;
      num_pkts_q   <= '0;
      pkt_len_q    <= LENW'(1);
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      flit_idx_q   <= '0;
      tx_pkt_cnt_q <= '0;
      dest_q       <= '0;
      rr_ptr_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start_run) begin
        num_pkts_q   <= num_pkts;
        pkt_len_q    <= (pkt_len == '0) ? LENW'(1) : pkt_len;
        gap_q        <= gap;
        tx_pkt_cnt_q <= '0;
      end
      if (enter_head) begin
        flit_idx_q <= '0;
        dest_q     <= next_dest;
        if (mode == MODE_RR) rr_ptr_q <= rr_next;
      end else if (tx_accept) begin
        flit_idx_q <= flit_idx_q + LENW'(1);
      end
      if (tx_accept && tx_last && tx_pkt_cnt_q != '1) tx_pkt_cnt_q <= tx_pkt_cnt_q + 16'd1;
      // Preloaded outside GAP so the count-down starts on the first idle cycle.
      if (state_q != TG_GAP) gap_cnt_q <= gap_q - 8'd1;
      else                   gap_cnt_q <= gap_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_len_q    <= '0;
      rx_pkt_cnt  <= '0;
      rx_flit_cnt <= '0;
      rx_err_cnt  <= '0;
    end else if (axis_s_tvalid) begin
      if (rx_flit_cnt != '1) rx_flit_cnt <= rx_flit_cnt + 32'd1;
      if (axis_s_tlast) begin
        rx_len_q <= '0;
        if (rx_pkt_cnt != '1) rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
        if ((17'(rx_len_q) + 17'd1) != 17'(pkt_len_q) && rx_err_cnt != '1)
          rx_err_cnt <= rx_err_cnt + 16'd1;
      end else if (rx_len_q != '1) begin
        rx_len_q <= rx_len_q + 16'd1;
      end
    end
  end

  assign rx_unused = ^{axis_s_tdata, axis_s_tdest};

  assign axis_m_tvalid = tx_valid;
  assign axis_m_tlast  = tx_last;
  assign axis_m_tdest  = dest_q;
  assign axis_m_tdata  = (state_q == TG_HEAD) ? TDATAW'(head_word(8'(SRC_ID), tx_pkt_cnt_q)) :
                         (state_q == TG_BODY) ? TDATAW'(lfsr_q) : '0;
  assign axis_s_tready = 1'b1;
  assign busy          = (state_q == TG_HEAD) || (state_q == TG_BODY) || (state_q == TG_GAP);
  assign done          = (state_q == TG_DONE);
  assign tx_pkt_cnt    = tx_pkt_cnt_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Randomised bench for axis_traffic_gen: packet-level reference model,
// stall-stability monitor, rx loopback and injected framing errors.
`timescale 1ns/1ps
module tb_axis_traffic_gen;

  localparam int          TDATAW      = 32;
  localparam int          TDESTW      = 4;
  localparam int          NUM_DESTS   = 4;
  localparam int          SRC_ID      = 0;
  localparam int          MAX_PKT_LEN = 16;
  localparam int          LENW        = 5;
  localparam logic [31:0] SEED        = 32'hACE1_2468;
  localparam logic [31:0] TAPS        = 32'h8020_0003;

  typedef struct packed {
    logic        last;
    logic [3:0]  dest;
    logic [31:0] data;
  } flit_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        mode = '0;
  logic [TDESTW-1:0] fixed_dest = '0;
  logic [15:0]       num_pkts = '0;
  logic [LENW-1:0]   pkt_len = '0;
  logic [7:0]        gap = '0;
  logic              m_tvalid, m_tlast;
  logic              m_tready = 1'b1;
  logic [TDATAW-1:0] m_tdata;
  logic [TDESTW-1:0] m_tdest;
  logic              s_tvalid, s_tready, s_tlast;
  logic [TDATAW-1:0] s_tdata;
  logic [TDESTW-1:0] s_tdest;
  logic              busy, done;
  logic [15:0]       tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt;
  logic [31:0]       rx_flit_cnt;

  logic              loopback = 1'b0;
  logic              inj_valid = 1'b0;
  logic              inj_last = 1'b0;
  logic [31:0]       inj_data = '0;
  int                ready_mode = 0;
  int                ready_phase = 0;
  int                idle_cnt = 0;

  int                checks = 0;
  int                errors = 0;

  flit_t             obs_q[$];
  flit_t             exp_q[$];
  logic [31:0]       lfsr_m = SEED;
  int                rr_m = 0;
  int                rx_len_m = 1;
  int                rx_pkt_m = 0;
  int                rx_flit_m = 0;
  int                rx_err_m = 0;

  assign s_tvalid = loopback ? (m_tvalid & m_tready) : inj_valid;
  assign s_tlast  = loopback ? m_tlast : inj_last;
  assign s_tdata  = loopback ? m_tdata : inj_data;
  assign s_tdest  = loopback ? m_tdest : 4'd0;

  axis_traffic_gen #(
    .TDATAW(TDATAW), .TDESTW(TDESTW), .NUM_DESTS(NUM_DESTS), .SRC_ID(SRC_ID),
    .SKIP_SELF(1'b1), .MAX_PKT_LEN(MAX_PKT_LEN), .LFSR_DW(32),
    .LFSR_DEFAULT(SEED), .LFSR_TAPS(TAPS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .fixed_dest(fixed_dest),
    .num_pkts(num_pkts), .pkt_len(pkt_len), .gap(gap),
    .axis_m_tvalid(m_tvalid), .axis_m_tready(m_tready), .axis_m_tdata(m_tdata),
    .axis_m_tlast(m_tlast), .axis_m_tdest(m_tdest),
    .axis_s_tvalid(s_tvalid), .axis_s_tready(s_tready), .axis_s_tdata(s_tdata),
    .axis_s_tlast(s_tlast), .axis_s_tdest(s_tdest),
    .busy(busy), .done(done), .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt),
    .rx_flit_cnt(rx_flit_cnt), .rx_err_cnt(rx_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {x[30:0], ^(x & TAPS)};
  endfunction

  // Reference: packets as lists of flits, destinations picked by the mode rules.
  task automatic build_expected(input logic [1:0] md, input int fd, input int np, input int len_eff);
    flit_t f;
    exp_q.delete();
    for (int p = 0; p < np; p++) begin
      int d;
      case (md)
        2'd1: begin
          rr_m = (rr_m + 1) % NUM_DESTS;
          if (rr_m == SRC_ID) rr_m = (rr_m + 1) % NUM_DESTS;
          d = rr_m;
        end
        2'd2: begin
          d = int'(lfsr_m[TDESTW-1:0]) % NUM_DESTS;
          if (d == SRC_ID) d = (d + 1) % NUM_DESTS;
        end
        default: d = fd;
      endcase
      f = {len_eff == 1, 4'(d), 8'(SRC_ID), 8'h00, 16'(p)};
      exp_q.push_back(f);
      for (int k = 1; k < len_eff; k++) begin
        f = {k == len_eff - 1, 4'(d), lfsr_m};
        exp_q.push_back(f);
        lfsr_m = lfsr_step(lfsr_m);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       m_tready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
        2:       m_tready = ($urandom_range(0, 2) != 0);
        default: m_tready = 1'b1;
      endcase
      ready_phase++;
    end
  end

  initial begin
    flit_t held;
    flit_t cur;
    logic  stalled;
    held = '0;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        cur = {m_tlast, m_tdest, m_tdata};
        if (stalled) begin
          check("stall_valid", 64'(m_tvalid), 64'(1));
          check("stall_hold", 64'(cur), 64'(held));
        end
        if (m_tvalid && m_tready) obs_q.push_back(cur);
        if (busy && !m_tvalid) idle_cnt++;
        stalled = m_tvalid && !m_tready;
        held = cur;
      end
    end
  end

  task automatic run_test(input string tag, input logic [1:0] md, input int fd, input int np,
                          input int len, input int gp, input int rm);
    int len_eff;
    int cyc;
    len_eff = (len == 0) ? 1 : len;
    build_expected(md, fd, np, len_eff);
    rx_len_m = len_eff;
    obs_q.delete();
    idle_cnt = 0;
    ready_mode = rm;
    @(posedge clk); #1;
    mode = md; fixed_dest = 4'(fd); num_pkts = 16'(np); pkt_len = LENW'(len); gap = 8'(gp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_after_start"}, 64'(done), 64'(np == 0));
    check({tag, "_busy_after_start"}, 64'(busy), 64'(np != 0));
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_done"}, 64'(done), 64'(1));
    check({tag, "_busy_end"}, 64'(busy), 64'(0));
    check({tag, "_tx_pkt_cnt"}, 64'(tx_pkt_cnt), 64'(np));
    check({tag, "_nflits"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_flit%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    if (rm == 0 && np > 0) check({tag, "_idle_cycles"}, 64'(idle_cnt), 64'((np - 1) * gp));
    ready_mode = 0;
  endtask

  task automatic inject(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      inj_valid = 1'b1;
      inj_last  = (i == n - 1);
      inj_data  = $urandom;
    end
    @(posedge clk); #1;
    inj_valid = 1'b0;
    inj_last  = 1'b0;
    rx_pkt_m++;
    rx_flit_m += n;
    if (n != rx_len_m) rx_err_m++;
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_rx_pkt"}, 64'(rx_pkt_cnt), 64'(rx_pkt_m));
    check({tag, "_rx_flit"}, 64'(rx_flit_cnt), 64'(rx_flit_m));
    check({tag, "_rx_err"}, 64'(rx_err_cnt), 64'(rx_err_m));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp[6];
    int cyc;
    int len_r;
    rr_exp = '{1, 2, 3, 1, 2, 3};

    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_tlast", 64'(m_tlast), 64'(0));
    check("rst_tdata", 64'(m_tdata), 64'(0));
    check("rst_tdest", 64'(m_tdest), 64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_tx_pkt", 64'(tx_pkt_cnt), 64'(0));
    check_rx("rst");
    rst = 1'b0;

    run_test("fixed", 2'd0, 3, 2, 4, 0, 0);
    if (obs_q.size() == 8) begin
      check("fixed_head0", 64'(obs_q[0].data), 64'h0000_0000);
      check("fixed_head1", 64'(obs_q[4].data), 64'h0000_0001);
      check("fixed_last3", 64'(obs_q[3].last), 64'(1));
      check("fixed_last7", 64'(obs_q[7].last), 64'(1));
    end

    run_test("stall", 2'd0, 3, 2, 4, 0, 1);

    run_test("rr", 2'd1, 0, 6, 1, 3, 0);
    for (int i = 0; i < 6 && i < obs_q.size(); i++)
      check($sformatf("rr_dest%0d", i), 64'(obs_q[i].dest), 64'(rr_exp[i]));

    len_r = $urandom_range(1, 4);
    run_test("rand", 2'd2, 0, 100, len_r, $urandom_range(0, 2), 2);
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (i == 0 || exp_q[i-1].last) begin
        check($sformatf("rand_not_self%0d", i), 64'(obs_q[i].dest != 4'(SRC_ID)), 64'(1));
        check($sformatf("rand_in_range%0d", i), 64'(obs_q[i].dest < 4'(NUM_DESTS)), 64'(1));
      end
    end

    run_test("len0", 2'd0, 2, 3, 0, 0, 2);
    run_test("zero", 2'd0, 1, 0, 4, 0, 0);

    loopback = 1'b1;
    run_test("loop", 2'd0, 1, 3, 5, 1, 0);
    loopback = 1'b0;
    rx_pkt_m  += 3;
    rx_flit_m += 15;
    check_rx("loop");
    inject(3);
    check_rx("inj3");
    inject(5);
    check_rx("inj5");
    inject(1);
    check_rx("inj1");

    obs_q.delete();
    ready_mode = 0;
    @(posedge clk); #1;
    mode = 2'd0; fixed_dest = 4'd2; num_pkts = 16'd3; pkt_len = LENW'(8); gap = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (obs_q.size() < 3 && cyc < 100) begin
      @(negedge clk); #2;
      cyc++;
    end
    check("mid_reached_body2", 64'(obs_q.size() >= 3), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(m_tvalid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_tx_pkt", 64'(tx_pkt_cnt), 64'(0));
    lfsr_m = SEED;
    rr_m = 0;
    rx_pkt_m = 0;
    rx_flit_m = 0;
    rx_err_m = 0;
    check_rx("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    run_test("post_rst", 2'd0, 2, 1, 3, 0, 0);
    if (obs_q.size() > 0) check("post_rst_head_seq0", 64'(obs_q[0].data), 64'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
